// File: rtl/alu_result_buffer.sv
// Collects one result per cycle from the ALU units into a small FIFO.
// Each entry is tagged with its producing unit. Sticky bits report dropped results.
module alu_result_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Arith_Out,
  input  logic              Arith_Flag,
  input  logic [DATA_W-1:0] Logic_Out,
  input  logic              Logic_Flag,
  input  logic [DATA_W-1:0] CMP_Out,
  input  logic              CMP_Flag,
  input  logic [DATA_W-1:0] Shift_Out,
  input  logic              Shift_Flag,
  input  logic              Out_Ready,
  input  logic              Clr_Err,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Out_Unit,
  output logic [CNT_W-1:0]  Count,
  output logic              Overflow_Err,
  output logic              Collision_Err
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [1:0]        r_unit [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf, r_coll;

  logic              w_wr_req, w_pop, w_full, w_wr, w_ovf, w_coll;
  logic [DATA_W-1:0] w_sel_data;
  logic [1:0]        w_sel_unit;

  always_comb begin
    w_sel_data = Shift_Out;
    w_sel_unit = 2'b11;
    if (Arith_Flag) begin
      w_sel_data = Arith_Out;
      w_sel_unit = 2'b00;
    end else if (Logic_Flag) begin
      w_sel_data = Logic_Out;
      w_sel_unit = 2'b01;
    end else if (CMP_Flag) begin
      w_sel_data = CMP_Out;
      w_sel_unit = 2'b10;
    end
  end

  assign w_wr_req = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
  assign w_coll   = (Arith_Flag & (Logic_Flag | CMP_Flag | Shift_Flag)) |
                    (Logic_Flag & (CMP_Flag | Shift_Flag)) |
                    (CMP_Flag & Shift_Flag);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_pop    = (r_count != '0) & Out_Ready;
  // A pop frees the slot at the same edge, so a full FIFO can still accept.
  assign w_wr     = w_wr_req & (~w_full | w_pop);
  assign w_ovf    = w_wr_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[r_wptr] <= w_sel_data;
      r_unit[r_wptr] <= w_sel_unit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_coll  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      // Set wins over clear when both land on the same edge.
      if (w_ovf)        r_ovf <= 1'b1;
      else if (Clr_Err) r_ovf <= 1'b0;
      if (w_coll)       r_coll <= 1'b1;
      else if (Clr_Err) r_coll <= 1'b0;
    end
  end

  assign Out_Valid     = (r_count != '0);
  assign Out_Data      = Out_Valid ? r_data[r_rptr] : '0;
  assign Out_Unit      = Out_Valid ? r_unit[r_rptr] : 2'b00;
  assign Count         = r_count;
  assign Overflow_Err  = r_ovf;
  assign Collision_Err = r_coll;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: hand-computed expectations for each scenario.
module tb_alu_result_buffer;
  logic        clk, rst;
  logic [15:0] Arith_Out, Logic_Out, CMP_Out, Shift_Out;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic        Out_Ready, Clr_Err;
  logic        Out_Valid;
  logic [15:0] Out_Data;
  logic [1:0]  Out_Unit;
  logic [2:0]  Count;
  logic        Overflow_Err, Collision_Err;

  int n_chk = 0;
  int n_err = 0;

  alu_result_buffer #(.DATA_W(16), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .Arith_Out(Arith_Out), .Arith_Flag(Arith_Flag),
    .Logic_Out(Logic_Out), .Logic_Flag(Logic_Flag),
    .CMP_Out(CMP_Out), .CMP_Flag(CMP_Flag),
    .Shift_Out(Shift_Out), .Shift_Flag(Shift_Flag),
    .Out_Ready(Out_Ready), .Clr_Err(Clr_Err),
    .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Unit(Out_Unit),
    .Count(Count), .Overflow_Err(Overflow_Err), .Collision_Err(Collision_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_flags();
    Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] d, input logic [1:0] u);
    chk({tag, "_valid"}, 32'(Out_Valid), 32'd1);
    chk({tag, "_data"},  32'(Out_Data),  32'(d));
    chk({tag, "_unit"},  32'(Out_Unit),  32'(u));
  endtask

  initial begin
    logic [15:0] exp_d [10];
    rst = 0; no_flags(); Out_Ready = 0; Clr_Err = 0;
    Arith_Out = 0; Logic_Out = 0; CMP_Out = 0; Shift_Out = 0;
    #12;
    chk("rst_valid", 32'(Out_Valid), 0);
    chk("rst_data",  32'(Out_Data), 0);
    chk("rst_unit",  32'(Out_Unit), 0);
    chk("rst_count", 32'(Count), 0);
    chk("rst_ovf",   32'(Overflow_Err), 0);
    chk("rst_coll",  32'(Collision_Err), 0);
    rst = 1;
    step();

    // 1: single CMP write, 1-cycle latency, then pop
    CMP_Flag = 1; CMP_Out = 16'd3;
    step(); no_flags();
    chk_head("t1", 16'd3, 2'b10);
    chk("t1_count", 32'(Count), 1);
    Out_Ready = 1;
    step(); Out_Ready = 0;
    chk("t1_cnt0",  32'(Count), 0);
    chk("t1_vld0",  32'(Out_Valid), 0);
    chk("t1_dat0",  32'(Out_Data), 0);

    // 2: fill from all four units, overflow, drain in order
    Arith_Flag = 1; Arith_Out = 16'h0001; step(); no_flags();
    Logic_Flag = 1; Logic_Out = 16'h00F0; step(); no_flags();
    CMP_Flag   = 1; CMP_Out   = 16'h0002; step(); no_flags();
    Shift_Flag = 1; Shift_Out = 16'hFFFE; step(); no_flags();
    chk("t2_full", 32'(Count), 4);
    chk("t2_noovf", 32'(Overflow_Err), 0);
    CMP_Flag = 1; CMP_Out = 16'h0003; step(); no_flags();
    chk("t2_ovf", 32'(Overflow_Err), 1);
    chk("t2_cnt", 32'(Count), 4);
    Out_Ready = 1;
    chk_head("t2_h0", 16'h0001, 2'b00); step();
    chk_head("t2_h1", 16'h00F0, 2'b01); step();
    chk_head("t2_h2", 16'h0002, 2'b10); step();
    chk_head("t2_h3", 16'hFFFE, 2'b11); step();
    Out_Ready = 0;
    chk("t2_empty", 32'(Count), 0);
    Clr_Err = 1; step(); Clr_Err = 0;
    chk("t2_clr", 32'(Overflow_Err), 0);

    // 3: collision, Arith wins
    Arith_Flag = 1; Arith_Out = 16'hFFFB; CMP_Flag = 1; CMP_Out = 16'h0001;
    step(); no_flags();
    chk("t3_cnt", 32'(Count), 1);
    chk_head("t3", 16'hFFFB, 2'b00);
    chk("t3_coll", 32'(Collision_Err), 1);
    Clr_Err = 1; step(); Clr_Err = 0;
    chk("t3_clr", 32'(Collision_Err), 0);
    Out_Ready = 1; step(); Out_Ready = 0;
    chk("t3_empty", 32'(Count), 0);

    // 4: full FIFO, simultaneous write+pop for 6 cycles, pointers wrap
    for (int i = 0; i < 4; i++) exp_d[i] = 16'(16'h10 + i);
    for (int i = 0; i < 6; i++) exp_d[4+i] = 16'(16'h20 + i);
    for (int i = 0; i < 4; i++) begin
      Shift_Flag = 1; Shift_Out = exp_d[i]; step();
    end
    no_flags();
    chk("t4_full", 32'(Count), 4);
    Out_Ready = 1;
    for (int i = 0; i < 6; i++) begin
      Shift_Flag = 1; Shift_Out = exp_d[4+i];
      chk_head($sformatf("t4_s%0d", i), exp_d[i], 2'b11);
      step();
      chk($sformatf("t4_c%0d", i), 32'(Count), 4);
    end
    no_flags();
    chk("t4_noovf", 32'(Overflow_Err), 0);
    for (int i = 6; i < 10; i++) begin
      chk_head($sformatf("t4_d%0d", i), exp_d[i], 2'b11);
      step();
    end
    Out_Ready = 0;
    chk("t4_empty", 32'(Count), 0);

    // 5: async reset mid-stream
    Arith_Flag = 1; Arith_Out = 16'd7; Logic_Flag = 1; Logic_Out = 16'd99; step(); no_flags();
    CMP_Flag = 1; CMP_Out = 16'd8; step();
    CMP_Out = 16'd9; step(); no_flags();
    chk("t5_cnt3", 32'(Count), 3);
    chk("t5_coll", 32'(Collision_Err), 1);
    #2 rst = 0;
    #1;
    chk("t5_vld", 32'(Out_Valid), 0);
    chk("t5_cnt", 32'(Count), 0);
    chk("t5_dat", 32'(Out_Data), 0);
    chk("t5_coll0", 32'(Collision_Err), 0);
    chk("t5_ovf0", 32'(Overflow_Err), 0);
    #1 rst = 1;
    CMP_Flag = 1; CMP_Out = 16'h0055;
    step(); no_flags();
    chk_head("t5_new", 16'h0055, 2'b10);
    chk("t5_ncnt", 32'(Count), 1);

    // 6: overflow and Clr_Err on the same edge
    for (int i = 0; i < 3; i++) begin
      CMP_Flag = 1; CMP_Out = 16'(i); step();
    end
    no_flags();
    chk("t6_full", 32'(Count), 4);
    Arith_Flag = 1; Arith_Out = 16'h1234; Clr_Err = 1;
    step(); no_flags(); Clr_Err = 0;
    chk("t6_ovf", 32'(Overflow_Err), 1);
    chk("t6_cnt", 32'(Count), 4);
    chk_head("t6_head", 16'h0055, 2'b10);
    Clr_Err = 1; step(); Clr_Err = 0;
    chk("t6_clr", 32'(Overflow_Err), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream collection stage for the signed ALU execution units (arithmetic, logic, compare, shift).
- Each cycle, accepts at most one registered unit result, selected by that unit's flag.
- Tags the result with the producing unit and queues it in a small FIFO.
- Presents queued results to the consumer over a valid/ready handshake. Sticky error bits report dropped results.

Parameters:
- DATA_W, 16, result width (signed two's complement); matches the unit output width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of Count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- Arith_Out  input  DATA_W  arithmetic unit result (signed).
- Arith_Flag  input  1  arithmetic result valid this cycle.
- Logic_Out  input  DATA_W  logic unit result.
- Logic_Flag  input  1  logic result valid.
- CMP_Out  input  DATA_W  compare unit result.
- CMP_Flag  input  1  compare result valid.
- Shift_Out  input  DATA_W  shift unit result.
- Shift_Flag  input  1  shift result valid.
- Out_Ready  input  1  consumer accepts the head entry.
- Clr_Err  input  1  clears the sticky error bits.
- Out_Valid  output  1  head entry available.
- Out_Data  output  DATA_W  head entry data (signed).
- Out_Unit  output  2  head entry tag: 00 arith, 01 logic, 10 cmp, 11 shift.
- Count  output  CNT_W  number of occupied entries, 0..DEPTH.
- Overflow_Err  output  1  sticky: a result was dropped because the FIFO was full.
- Collision_Err  output  1  sticky: two or more flags were high in the same cycle.

Behaviour:
- Reset (rst low, asynchronous): pointers, Count, Overflow_Err and Collision_Err go to 0; Out_Valid=0, Out_Data=0, Out_Unit=0. Storage contents don't matter. Reset asserted mid-stream discards all queued entries.
- Write request: any flag high at a rising edge. Each cycle a flag is high counts as one new result; a flag held high for N cycles produces N entries.
- Unit select priority: Arith > Logic > CMP > Shift. Only the highest-priority result is written.
  - If two or more flags are high in one cycle, Collision_Err is set at that edge. Lower-priority results are discarded.
- Pop: occurs at an edge when Out_Valid && Out_Ready. Out_Ready while empty has no effect.
- Head presentation:
  - Out_Valid = (Count != 0).
  - Out_Data/Out_Unit come directly from the head storage register, with no combinational path from the unit inputs.
  - Both are forced to 0 when empty.
  - Write-to-output latency is 1 cycle: a result written at edge k is visible after edge k, when the FIFO was empty.
- Full (Count==DEPTH):
  - Write without pop: the result is dropped, Overflow_Err is set, contents are unchanged.
  - Write with pop in the same cycle: both happen, Count stays DEPTH, no error.
- Empty with write and Out_Ready high: no bypass. The entry is written and popped on a later edge.
- Simultaneous write and pop when not full: Count unchanged, head advances, new entry goes to the tail.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately, which resolves full vs. empty.
- Data is stored bit-exact; no sign extension or modification.
- Clr_Err clears both sticky bits at the edge. If an error event occurs in the same cycle, the error bit is set (set wins over clear).
- Out_Data/Out_Unit must stay stable while Out_Valid=1 and Out_Ready=0.

Test Plan:
1. Reset, then CMP_Flag=1, CMP_Out=16'sd3 for one cycle. Next cycle: Out_Valid=1, Out_Data=3, Out_Unit=10, Count=1. Out_Ready=1 for one cycle, then Count=0, Out_Valid=0, Out_Data=0.
2. With Out_Ready=0, write Arith 0x0001, Logic 0x00F0, CMP 0x0002, Shift 0xFFFE (-2) on consecutive cycles. Count=4. A fifth write (CMP 0x0003) sets Overflow_Err=1 and Count stays 4. Drain with Out_Ready=1: outputs in order 1/00, 0x00F0/01, 2/10, 0xFFFE/11.
3. Arith_Flag and CMP_Flag high together (Arith_Out=-5, CMP_Out=1). One entry, Data=0xFFFB, Unit=00. Collision_Err=1. Then Clr_Err=1 with no flags: Collision_Err=0.
4. Fill to 4, then hold Out_Ready=1 while Shift_Flag stays high for 6 cycles. Count stays 4, no Overflow_Err. Pointers wrap and the drain order matches the write order.
5. Fill 3 entries, pulse rst low asynchronously between clock edges. Immediately: Out_Valid=0, Count=0, Out_Data=0, errors 0. Afterwards a new CMP result appears with 1-cycle latency.
6. Full FIFO with Overflow event and Clr_Err in the same cycle: Overflow_Err stays 1.
